// File: rtl/trig_pkg.sv
// Shared encodings for the coincidence trigger: mode codes, FSM states and the clock period.
package trig_pkg;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_MAJ = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int CLK_PERIOD_NS = 5;

endpackage

// File: rtl/trig_sync.sv
// Single-bit multi-flop synchroniser bringing an asynchronous coax input into the clk domain.
module trig_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trig_coinc_n.sv
// Coincidence trigger: OR / AND / majority decision over masked synchronised inputs,
// followed by a fixed-width output pulse and a programmable dead time.
module trig_coinc_n
  import trig_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int CNT_W       = 16,
  parameter int TCNT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_IN-1:0]            trig_in,
  input  logic [N_IN-1:0]            chan_mask,
  input  logic [1:0]                 mode,
  input  logic [$clog2(N_IN+1)-1:0]  threshold,
  input  logic [CNT_W-1:0]           fire_len,
  input  logic [CNT_W-1:0]           dead_len,
  input  logic                       arm,
  input  logic                       cnt_clr,
  output logic                       trig_out,
  output logic                       busy,
  output logic [TCNT_W-1:0]          trig_count
);

  localparam int TH_W = $clog2(N_IN + 1);

  logic [N_IN-1:0]   s;
  logic [N_IN-1:0]   act;
  logic [TH_W-1:0]   hit;
  logic              cond;
  logic              start;
  logic [CNT_W-1:0]  fire_eff;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  fire_sh_q;
  logic [CNT_W-1:0]  dead_sh_q;
  logic              trig_out_q;
  logic              busy_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [TCNT_W-1:0] tcnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_sync
      trig_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d_i  (trig_in[gi]),
        .q_o  (s[gi])
      );
    end
  endgenerate

  assign act = s & chan_mask;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_IN; i++) begin
      hit = hit + TH_W'(act[i]);
    end
  end

  // An empty mask never fires, whatever the mode.
  always_comb begin
    cond = 1'b0;
    if (chan_mask != '0) begin
      case (mode)
        MODE_OR:  cond = (hit != '0);
        MODE_AND: cond = (act == chan_mask);
        MODE_MAJ: cond = (threshold != '0) && (hit >= threshold);
        default:  cond = 1'b0;
      endcase
    end
  end

  assign start    = (state_q == IDLE) && arm && cond;
  assign fire_eff = (fire_len == '0) ? CNT_W'(1) : fire_len;

  // Clear wins over a simultaneous FIRE entry; increment saturates at all-ones.
  always_comb begin
    tcnt_d = tcnt_q;
    if (cnt_clr) begin
      tcnt_d = '0;
    end else if (start && (tcnt_q != '1)) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fire_sh_q  <= '0;
      dead_sh_q  <= '0;
      trig_out_q <= 1'b0;
      busy_q     <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FIRE;
            fire_sh_q  <= fire_eff;
            dead_sh_q  <= dead_len;
            cnt_q      <= CNT_W'(1);
            trig_out_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FIRE: begin
          if (cnt_q == fire_sh_q) begin
            trig_out_q <= 1'b0;
            cnt_q      <= CNT_W'(1);
            if (dead_sh_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DEAD;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DEAD: begin
          if (cnt_q == dead_sh_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          trig_out_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign trig_out   = trig_out_q;
  assign busy       = busy_q;
  assign trig_count = tcnt_q;

endmodule

// File: tb/tb_trig_coinc_n.sv
// Directed bench for trig_coinc_n: hand-computed latencies, pulse widths and counter values.
`timescale 1ns/1ps
module tb_trig_coinc_n;
  import trig_pkg::*;

  localparam int N_IN   = 4;
  localparam int CNT_W  = 16;
  localparam int TCNT_W = 3;
  localparam int SS     = 2;

  logic              clk = 1'b0;
  logic              nrst;
  logic [N_IN-1:0]   trig_in;
  logic [N_IN-1:0]   chan_mask;
  logic [1:0]        mode;
  logic [2:0]        threshold;
  logic [CNT_W-1:0]  fire_len;
  logic [CNT_W-1:0]  dead_len;
  logic              arm;
  logic              cnt_clr;
  logic              trig_out;
  logic              busy;
  logic [TCNT_W-1:0] trig_count;

  int vectors    = 0;
  int miscompares = 0;

  trig_coinc_n #(
    .N_IN(N_IN), .CNT_W(CNT_W), .TCNT_W(TCNT_W), .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .trig_in    (trig_in),
    .chan_mask  (chan_mask),
    .mode       (mode),
    .threshold  (threshold),
    .fire_len   (fire_len),
    .dead_len   (dead_len),
    .arm        (arm),
    .cnt_clr    (cnt_clr),
    .trig_out   (trig_out),
    .busy       (busy),
    .trig_count (trig_count)
  );

  always #(CLK_PERIOD_NS / 2.0) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int max, output int n);
    n = 0;
    while (!trig_out && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic high_len(output int h);
    h = 0;
    while (trig_out && h < 100) begin
      tick();
      h++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    int h;
    nrst = 1'b0; trig_in = '0; chan_mask = '0; mode = MODE_OR; threshold = '0;
    fire_len = 16'd5; dead_len = 16'd20; arm = 1'b0; cnt_clr = 1'b0;
    repeat (3) tick();
    chk("rst_trig_out", 32'(trig_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(trig_count), 32'd0);
    nrst = 1'b1;

    // OR, level held: 5 high, 20 dead, retrigger 26 cycles after first rise
    chan_mask = 4'b0011; arm = 1'b1; trig_in = 4'b0010;
    wait_rise(50, n);
    chk("or_latency", 32'(n), 32'(SS + 1));
    chk("or_busy", 32'(busy), 32'd1);
    chk("or_count1", 32'(trig_count), 32'd1);
    high_len(h);
    chk("or_high", 32'(h), 32'd5);
    chk("or_dead_busy", 32'(busy), 32'd1);
    wait_rise(100, n);
    chk("or_period", 32'(h + n), 32'd26);
    chk("or_count2", 32'(trig_count), 32'd2);
    trig_in = '0;
    wait_idle("or_idle");

    // AND mask 0101
    mode = MODE_AND; chan_mask = 4'b0101; trig_in = 4'b0001;
    wait_rise(10, n);
    chk("and_partial_none", 32'(n), 32'd10);
    trig_in = 4'b0101;
    wait_rise(20, n);
    chk("and_latency", 32'(n), 32'(SS + 1));
    trig_in = '0;
    high_len(h);
    chk("and_high", 32'(h), 32'd5);
    wait_idle("and_idle");
    chk("and_count", 32'(trig_count), 32'd3);

    // Majority threshold 3
    mode = MODE_MAJ; chan_mask = 4'b1111; threshold = 3'd3; trig_in = 4'b0011;
    wait_rise(10, n);
    chk("maj_2of3_none", 32'(n), 32'd10);
    trig_in = 4'b0111;
    wait_rise(20, n);
    chk("maj_3_latency", 32'(n), 32'(SS + 1));
    trig_in = '0;
    wait_idle("maj_idle");
    threshold = 3'd0; trig_in = 4'b1111;
    wait_rise(10, n);
    chk("maj_thr0_none", 32'(n), 32'd10);
    mode = 2'b11;
    wait_rise(10, n);
    chk("mode11_none", 32'(n), 32'd10);
    chk("maj_count", 32'(trig_count), 32'd4);

    // arm gating, then drop arm mid-FIRE
    mode = MODE_OR; arm = 1'b0;
    wait_rise(10, n);
    chk("arm_low_none", 32'(n), 32'd10);
    arm = 1'b1;
    wait_rise(10, n);
    chk("arm_rise", 32'(n), 32'd1);
    arm = 1'b0;
    high_len(h);
    chk("arm_drop_high", 32'(h), 32'd5);
    wait_rise(60, n);
    chk("arm_drop_no_retrig", 32'(n), 32'd60);
    chk("arm_count", 32'(trig_count), 32'd5);

    // fire_len 0, dead_len 0: one-cycle pulse every 2 cycles, counter saturates
    fire_len = 16'd0; dead_len = 16'd0; arm = 1'b1;
    wait_rise(10, n);
    chk("min_rise", 32'(n), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("min_low", 32'(trig_out), 32'd0);
      tick();
      chk("min_high", 32'(trig_out), 32'd1);
    end
    chk("sat_count", 32'(trig_count), 32'd7);
    tick();
    cnt_clr = 1'b1;
    tick();
    chk("clr_trig_out", 32'(trig_out), 32'd1);
    chk("clr_wins", 32'(trig_count), 32'd0);
    cnt_clr = 1'b0;
    tick();
    tick();
    chk("clr_then_inc", 32'(trig_count), 32'd1);

    // Asynchronous reset mid-FIRE
    trig_in = '0;
    wait_idle("rst_pre_idle");
    repeat (4) tick();
    fire_len = 16'd10; dead_len = 16'd5; trig_in = 4'b0001;
    wait_rise(20, n);
    chk("rst_pre_rise", 32'(n), 32'(SS + 1));
    tick();
    tick();
    nrst = 1'b0;
    #1;
    chk("rst_async_trig_out", 32'(trig_out), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_count", 32'(trig_count), 32'd0);
    tick();
    nrst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trig_coinc_n.md
# trig_coinc_n

Parametrised coincidence trigger for the trigger board. It takes N_IN asynchronous coax discriminator inputs and applies a per-channel enable mask. It forms an OR, AND or majority (≥ threshold) decision and emits a fixed-width trigger pulse, followed by a programmable dead time. It replaces the fixed two-input OR / 5-cycle fire / 20-cycle dead trigger and adds an arm control and a trigger counter. It sits between the coax input pins and the coax trigger output, in the 200 MHz PLL domain.

## Interface
- N_IN, default 4: number of trigger inputs (≥ 1).
- CNT_W, default 16: width of the fire and dead length counters.
- TCNT_W, default 32: width of the trigger counter.
- SYNC_STAGES, default 2: synchroniser depth per input (≥ 2).
- clk  in  1  200 MHz system clock (5 ns tick).
- nrst  in  1  reset, asynchronous assert, active-low.
- trig_in  in  N_IN  raw coax inputs, asynchronous to clk.
- chan_mask  in  N_IN  1 = channel participates.
- mode  in  2  00 OR, 01 AND, 10 majority, 11 reserved (never fires).
- threshold  in  clog2(N_IN+1)  majority threshold.
- fire_len  in  CNT_W  output pulse length in cycles.
- dead_len  in  CNT_W  dead time in cycles after the pulse.
- arm  in  1  1 = new triggers are accepted.
- cnt_clr  in  1  synchronous clear of trig_count.
- trig_out  out  1  trigger pulse, registered.
- busy  out  1  high in FIRE or DEAD.
- trig_count  out  TCNT_W  number of FIRE entries, saturating.

## Operation
- Each trig_in bit passes through a SYNC_STAGES flop chain. Call the result s[i]. Decisions use only s & chan_mask.
- hit = popcount(s & chan_mask). The condition is:
  - OR: hit ≥ 1.
  - AND: chan_mask ≠ 0 and (s & chan_mask) == chan_mask.
  - majority: threshold ≠ 0 and hit ≥ threshold.
  - Mode 11 or mask 0: the condition is always false.
- The FSM has three states: IDLE, FIRE, DEAD.
  - IDLE → FIRE when arm & condition. On entry, fire_len and dead_len are latched into shadow registers. A fire_len of 0 is treated as 1.
  - FIRE lasts exactly latched fire_len cycles, with trig_out = 1. It then goes to DEAD, or straight to IDLE if latched dead_len = 0.
  - DEAD lasts exactly latched dead_len cycles with trig_out = 0, then returns to IDLE.
  - Inputs are ignored in FIRE and DEAD. A level that is still high on return to IDLE retriggers (the block is level-sensitive).
- arm is checked only in IDLE. Deasserting arm mid-FIRE or mid-DEAD does not abort the sequence.
- Config changes in FIRE or DEAD take effect only at the next FIRE entry. mask, mode and threshold are used live in IDLE.
- trig_count increments by 1 on each IDLE → FIRE transition and saturates at all-ones.
  - cnt_clr has priority over the increment, so a simultaneous clear and trigger results in 0.
- Reset values: trig_out = 0, busy = 0, trig_count = 0, state = IDLE, all synchroniser flops = 0, shadow registers = 0.
  - Reset asserted mid-pulse drops trig_out asynchronously.

## Timing
- Latency: trig_in is first sampled high at edge k. s goes high after edge k+SYNC_STAGES−1. trig_out and busy rise after edge k+SYNC_STAGES.
- Pulse high for exactly fire_len edges; busy high for fire_len + dead_len edges.
- Earliest retrigger: the condition is evaluated in the first IDLE cycle after DEAD. The minimum spacing between trig_out rising edges is fire_len + dead_len + 1 cycles (with dead_len = 0: fire_len + 1).
- Input pulses shorter than one clk period may be missed. There is no pulse stretching.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package trig_pkg holds:
  - mode encodings MODE_OR, MODE_AND, MODE_MAJ;
  - the state enum IDLE/FIRE/DEAD;
  - the CLK_PERIOD_NS = 5 constant.
- Sub-module trig_sync: SYNC_STAGES-deep single-bit synchroniser with async active-low reset, instantiated N_IN times.
- The popcount, condition logic, FSM, shadow registers and counter stay in trig_coinc_n.

## Test plan
- OR, mask 0011, fire_len 5, dead_len 20, trig_in[1] held high → trig_out high 5 cycles, low 20, high again. trig_count goes 1 then 2, with 26 cycles between rising edges.
- AND, mask 0101, pulse trig_in[0] only → no trigger. Then trig_in[0] and trig_in[2] together → one 5-cycle pulse, rising SYNC_STAGES+1 edges after sampling.
- Majority, threshold 3, N_IN 4, mask 1111: 2 inputs high → none; 3 high → trigger. Threshold 0 with all high → none.
- arm low with all inputs high → no trigger. Deassert arm mid-FIRE → the pulse completes its full fire_len and no further triggers occur.
- fire_len 0, dead_len 0 with continuous OR → 1-cycle pulses every 2 cycles.
- nrst asserted mid-FIRE → trig_out 0 immediately and trig_count 0. trig_count at all-ones → it stays at all-ones. cnt_clr together with a trigger → 0.
